// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg
// Shared definitions for the 4-bit adder BIST controller:
//   - bist_state_t : controller state encoding (IDLE, SETTLE, CHECK, DONE)
//   - default operand width and settle time
//   - helpers deriving vector/counter widths from the operand width
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    localparam int DEFAULT_WIDTH         = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 1;
    localparam int DEFAULT_VEC_W         = 2 * DEFAULT_WIDTH;
    localparam int DEFAULT_VEC_COUNT     = 1 << DEFAULT_VEC_W;

    // {A,B} vector counter width.
    function automatic int vec_width(input int width);
        return 2 * width;
    endfunction

    // Error counter must hold the full 2^(2*WIDTH) count without saturating.
    function automatic int err_width(input int width);
        return 2 * width + 1;
    endfunction

    // Settle counter only needs to reach SETTLE_CYCLES-1; keep at least 1 bit.
    function automatic int settle_cnt_width(input int settle_cycles);
        return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    endfunction

endpackage

// File: rtl/adder_bist_controller_vector_gen.sv
// bist_vector_gen
// 2*WIDTH-bit operand vector counter for the adder BIST sweep.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset (counter -> 0)
//   clr   in  restart the sweep from vector 0
//   inc   in  advance to the next {A,B} vector
//   a     out upper half of the vector (operand A)
//   b     out lower half of the vector (operand B)
//   last  out high when the counter holds the all-ones vector
module bist_vector_gen
    import adder_bist_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last
);

    localparam int VW = vec_width(WIDTH);

    logic [VW-1:0] vec;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vec <= '0;
        end else if (inc) begin
            vec <= vec + VW'(1);
        end
    end

    assign a    = vec[VW-1:WIDTH];
    assign b    = vec[WIDTH-1:0];
    assign last = &vec;

endmodule

// File: rtl/adder_bist_controller.sv
// adder_bist_controller
// Exhaustive built-in self-test for a WIDTH-bit combinational adder. Every
// {A,B} combination is held for SETTLE_CYCLES cycles, then SUM is sampled
// once and compared against A+B. Mismatches are counted and the first
// failing vector and its SUM are captured.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle sweep request (accepted in IDLE or DONE)
//   sum_in          SUM from the adder under test (WIDTH+1 bits)
//   a_out, b_out    operands driven to the adder under test
//   busy            sweep in progress
//   done            sweep finished; results valid until next start or rst
//   pass            1 iff err_count==0 (valid with done)
//   err_count       mismatching vectors in the last sweep
//   first_fail_vec  {A,B} of the first mismatch, 0 if none
//   first_fail_sum  sum_in seen at the first mismatch, 0 if none
module adder_bist_controller
    import adder_bist_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH:0]     sum_in,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [2*WIDTH-1:0] first_fail_vec,
    output logic [WIDTH:0]     first_fail_sum
);

    localparam int EW = err_width(WIDTH);
    localparam int SW = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    bist_state_t   state;
    logic [SW-1:0] settle_cnt;
    logic          accept_start;
    logic          vec_inc;
    logic          vec_last;
    logic [WIDTH:0] golden;
    logic          mismatch;

    // start is only honoured between sweeps; mid-sweep pulses are dropped.
    assign accept_start = start && ((state == IDLE) || (state == DONE));

    // The last vector is never incremented, so operands hold it in DONE and
    // the counter never wraps.
    assign vec_inc = (state == CHECK) && !vec_last;

    assign golden   = {1'b0, a_out} + {1'b0, b_out};
    assign mismatch = (state == CHECK) && (sum_in != golden);

    bist_vector_gen #(
        .WIDTH (WIDTH)
    ) u_vector_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_start),
        .inc  (vec_inc),
        .a    (a_out),
        .b    (b_out),
        .last (vec_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_sum <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= SETTLE;
                        settle_cnt     <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        first_fail_sum <= '0;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= CHECK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + EW'(1);
                        if (err_count == '0) begin
                            first_fail_vec <= {a_out, b_out};
                            first_fail_sum <= sum_in;
                        end
                    end
                    if (vec_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Include this cycle's compare, since err_count
                        // has not absorbed it yet.
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state <= SETTLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_controller.sv
// Self-checking bench for adder_bist_controller. Two instances: default
// settle time (faulty adder models selectable) and SETTLE_CYCLES=3 (SUM is
// corrupted during the settle cycles of every vector).
module tb_adder_bist_controller;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, start2;
    logic [4:0] sum1, sum2;
    logic [3:0] a1, b1, a2, b2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [8:0] err1, err2;
    logic [7:0] ffv1, ffv2;
    logic [4:0] ffs1, ffs2;

    int         checks = 0;
    int         errors = 0;

    // Fault model selection for the adder feeding instance 1:
    // 0 correct, 1 SUM[4] stuck at 0, 2 SUM[0] inverted,
    // 4 random mask XORed onto two random vectors.
    int         mode = 0;
    logic [7:0] fv_a = 8'h00;
    logic [7:0] fv_b = 8'h00;
    logic [4:0] fmask = 5'h00;
    int         k2 = 0;

    function automatic logic [4:0] adder_model(input int m, input logic [3:0] a, input logic [3:0] b,
                                               input logic [7:0] va, input logic [7:0] vb,
                                               input logic [4:0] msk);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            1: s[4] = 1'b0;
            2: s[0] = ~s[0];
            4: if (({a, b} == va) || ({a, b} == vb)) s = s ^ msk;
            default: ;
        endcase
        return s;
    endfunction

    assign sum1 = adder_model(mode, a1, b1, fv_a, fv_b, fmask);

    // Cycles since instance 2 accepted start; only every 4th cycle of a
    // vector (the sampling cycle) carries a correct SUM.
    always @(posedge clk) k2 <= start2 ? 0 : k2 + 1;
    assign sum2 = ((k2 % 4) == 3) ? ({1'b0, a2} + {1'b0, b2}) : ~({1'b0, a2} + {1'b0, b2});

    adder_bist_controller dut1 (
        .clk(clk), .rst(rst), .start(start1), .sum_in(sum1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_sum(ffs1)
    );

    adder_bist_controller #(.WIDTH(4), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sum_in(sum2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_vec(ffv2), .first_fail_sum(ffs2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Expected sweep results straight from the fault model: scan all
    // vectors in {A,B} order and compare against true A+B.
    task automatic expect_results(input int m, output int e_err, output int e_vec, output int e_sum);
        logic [4:0] s;
        e_err = 0;
        e_vec = 0;
        e_sum = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                s = adder_model(m, a[3:0], b[3:0], fv_a, fv_b, fmask);
                if (s != 5'(a + b)) begin
                    if (e_err == 0) begin
                        e_vec = a * 16 + b;
                        e_sum = int'(s);
                    end
                    e_err++;
                end
            end
        end
    endtask

    // Pulse start on instance sel, then count cycles until done (bounded).
    task automatic run_sweep(input int sel, input int settle, input int repulse_at,
                             input int probe, output int cycles);
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        chk("busy_on_start", 64'(sel == 1 ? busy1 : busy2), 64'd1);
        chk("done_clear",    64'(sel == 1 ? done1 : done2), 64'd0);
        chk("pass_clear",    64'(sel == 1 ? pass1 : pass2), 64'd0);
        chk("err_clear",     64'(sel == 1 ? err1 : err2), 64'd0);
        chk("first_vec0",    64'(sel == 1 ? {a1, b1} : {a2, b2}), 64'd0);
        cycles = 0;
        while (!(sel == 1 ? done1 : done2) && cycles < 4000) begin
            @(negedge clk);
            if (cycles == repulse_at) begin
                if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
            end
            @(posedge clk); #1;
            start1 = 1'b0;
            start2 = 1'b0;
            cycles++;
            if (cycles == probe) begin
                chk("probe_vec",  64'(sel == 1 ? {a1, b1} : {a2, b2}), 64'(cycles / (settle + 1)));
                chk("probe_busy", 64'(sel == 1 ? busy1 : busy2), 64'd1);
            end
        end
        chk("busy_fall", 64'(sel == 1 ? busy1 : busy2), 64'd0);
    endtask

    task automatic sweep_and_check(input int m, input int repulse_at);
        int cyc, e_err, e_vec, e_sum;
        mode = m;
        repeat ($urandom_range(0, 4)) @(posedge clk);
        run_sweep(1, 1, repulse_at, int'($urandom_range(1, 511)), cyc);
        expect_results(m, e_err, e_vec, e_sum);
        chk("done_cycles", 64'(cyc), 64'd512);
        chk("done",        64'(done1), 64'd1);
        chk("pass",        64'(pass1), 64'(e_err == 0));
        chk("err_count",   64'(err1), 64'(e_err));
        chk("ff_vec",      64'(ffv1), 64'(e_vec));
        chk("ff_sum",      64'(ffs1), 64'(e_sum));
        chk("hold_last",   64'({a1, b1}), 64'hFF);
    endtask

    initial begin
        int cyc;
        int cnt;
        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a",    64'(a1), 64'd0);
        chk("rst_b",    64'(b1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_pass", 64'(pass1), 64'd0);
        chk("rst_err",  64'(err1), 64'd0);
        chk("rst_ffv",  64'(ffv1), 64'd0);
        chk("rst_ffs",  64'(ffs1), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Correct adder, SUM[4] stuck (with an ignored mid-sweep start),
        // SUM[0] inverted (started from DONE).
        sweep_and_check(0, -1);
        sweep_and_check(1, 100);
        sweep_and_check(2, -1);

        // Random sparse faults.
        for (int i = 0; i < 2; i++) begin
            fv_a  = 8'($urandom);
            fv_b  = 8'($urandom);
            fmask = 5'($urandom_range(1, 31));
            sweep_and_check(4, int'($urandom_range(1, 500)));
        end

        // Longer settle time with SUM garbage outside the sampling cycle.
        run_sweep(2, 3, -1, int'($urandom_range(1, 1023)), cyc);
        chk("s3_cycles", 64'(cyc), 64'd1024);
        chk("s3_done",   64'(done2), 64'd1);
        chk("s3_pass",   64'(pass2), 64'd1);
        chk("s3_err",    64'(err2), 64'd0);
        chk("s3_ffv",    64'(ffv2), 64'd0);

        // Reset in the middle of a sweep, with start asserted alongside.
        mode = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cnt = 0;
        while (!((a1 == 4'd6) && (b1 == 4'd4)) && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("reach_64", 64'((a1 == 4'd6) && (b1 == 4'd4)), 64'd1);
        @(negedge clk);
        rst    = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_a",    64'(a1), 64'd0);
        chk("mid_rst_b",    64'(b1), 64'd0);
        chk("mid_rst_busy", 64'(busy1), 64'd0);
        chk("mid_rst_done", 64'(done1), 64'd0);
        chk("mid_rst_err",  64'(err1), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        start1 = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst", 64'(busy1), 64'd0);
        sweep_and_check(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_bist_controller.md
# adder_bist_controller

Sequential built-in self-test driver and checker for the combinational 4-bit adder.
- Drives every {A,B} operand combination into the adder under test, waits a programmable settle time, and samples its SUM.
- Compares each SUM against an internal golden sum, counts mismatches, captures the first failing vector, and reports pass/fail through a start/busy/done handshake.
- Sits beside the adder in silicon, replacing the simulation-only exhaustive sweep with synthesizable hardware.

## Interface
- WIDTH, 4, operand width; SUM width is WIDTH+1, vector space is 2^(2·WIDTH)
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range ≥1
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a sweep; honoured only in IDLE or DONE
- sum_in  in  WIDTH+1  SUM from adder under test
- a_out  out  WIDTH  operand A to adder under test
- b_out  out  WIDTH  operand B to adder under test
- busy  out  1  high while a sweep is running
- done  out  1  high from sweep completion until next accepted start or rst
- pass  out  1  valid when done; 1 iff err_count==0
- err_count  out  2·WIDTH+1  number of mismatching vectors in last sweep
- first_fail_vec  out  2·WIDTH  {A,B} of first mismatch; 0 if none
- first_fail_sum  out  WIDTH+1  sum_in captured at first mismatch; 0 if none

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: a_out=b_out=0, busy=0.
  - start → clear vector counter, err_count, first_fail_*, done, pass.
  - Go to SETTLE.
- SETTLE: {a_out,b_out} = vector counter; busy=1.
  - Settle counter runs SETTLE_CYCLES cycles, then → CHECK.
- CHECK: compare sum_in with golden = a_out + b_out, zero-extended to WIDTH+1, full-width compare.
  - On mismatch: err_count+1.
  - If err_count was 0, capture first_fail_vec={a_out,b_out} and first_fail_sum=sum_in.
  - Last vector (all ones) → DONE; else vector+1 → SETTLE.
- DONE: busy=0, done=1, pass=(err_count==0).
  - Operands hold the last vector.
  - Results are held.
  - start → same clearing as IDLE, then → SETTLE.
- start in SETTLE/CHECK is ignored.
- No saturation needed: err_count width holds the full 2^(2·WIDTH) count.
- Vector counter is 2·WIDTH bits. Wrap from all-ones is never taken, because the last vector exits to DONE.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters 0.
- rst asserted mid-sweep: next edge returns to IDLE with every output 0; the sweep is not resumed.
- rst has priority over start in the same cycle.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE, then 1 in CHECK.
- sum_in is sampled only in the CHECK cycle. The DUT sees the new operands ≥SETTLE_CYCLES cycles before sampling.
- busy rises on the edge that samples start.
- done rises, and busy falls, exactly 2^(2·WIDTH)·(SETTLE_CYCLES+1) cycles after that edge. Default: 512.
- err_count and first_fail_* update on the CHECK-cycle edge. They are final when done rises.

## Structure
- Package adder_bist_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - localparams for vector count and counter widths derived from WIDTH;
  - the default SETTLE_CYCLES.
- One natural sub-module, bist_vector_gen: the 2·WIDTH-bit vector counter with clear, increment and last-vector flag, splitting its output into a_out/b_out.
- FSM, settle counter, golden compare and result registers stay in the top.

## Test plan
- Correct adder, defaults, start pulse → busy for 512 cycles, then done=1, pass=1, err_count=0, first_fail_vec=0x00, first_fail_sum=0x00.
- Adder with SUM[4] stuck at 0 → done at 512, pass=0, err_count=120, first_fail_vec=0x1F (A=1,B=15), first_fail_sum=0x00.
- Adder with SUM[0] inverted → err_count=256, first_fail_vec=0x00, first_fail_sum=0x01.
- SETTLE_CYCLES=3 with correct adder → done rises exactly 1024 cycles after start. sum_in is sampled only in the 4th cycle of each vector: corrupt sum_in during cycles 1–3 of every vector → still pass=1.
- start re-pulsed at cycle 100 of a sweep → ignored, done still at cycle 512. start in DONE → done/pass/err_count clear next edge, new sweep completes 512 cycles later.
- rst asserted while a_out=6,b_out=4 mid-sweep → next edge all outputs 0, state IDLE. A subsequent start gives a full 512-cycle sweep from vector 0x00.
